// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - round-robin bus arbiter with one dead cycle between owners
//
// Grants a shared bus to one of NREQ requesters and drives the binary select
// of the bus mux tree. A TURN cycle with no owner separates any two grants, so
// two sources never drive the bus in the same cycle.
//
// Optional feature macro: BUS_ARB_TIMEOUT_EN (forced revoke after MAX_HOLD
// grant cycles when another requester is waiting).
//
// Ports:
//   clock     in   1     rising-edge clock
//   clear     in   1     asynchronous active-high reset
//   req       in   NREQ  request level per source, held high while in use
//   grant     out  NREQ  one-hot grant, zero when the bus has no owner
//   sel       out  SELW  binary index of current/last owner (bus mux select)
//   bus_valid out  1     grant[sel] owns the bus this cycle
//   timeout   out  1     one-cycle pulse on a forced revoke

module bus_arbiter #(
  parameter int NREQ     = 32,
  parameter int SELW     = 5,
  parameter int MAX_HOLD = 16
) (
  input  logic            clock,
  input  logic            clear,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] grant,
  output logic [SELW-1:0] sel,
  output logic            bus_valid,
  output logic            timeout
);

  if (NREQ < 1 || NREQ > (1 << SELW)) begin : g_bad_nreq
    $error("bus_arbiter: NREQ must be in 1..2**SELW");
  end
  if (MAX_HOLD < 2) begin : g_bad_hold
    $error("bus_arbiter: MAX_HOLD must be at least 2");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } state_t;

  state_t          state, state_n;
  logic [SELW-1:0] last, last_n;
  logic [SELW-1:0] sel_n;
  logic [NREQ-1:0] grant_n;
  logic            bus_valid_n;

  logic [SELW-1:0] winner;
  logic [SELW-1:0] win_hi, win_lo;
  logic            found_hi, found_lo;
  logic            any_req;
  logic            owner_req;
  logic            revoke;

  assign any_req   = |req;
  // grant is one-hot on sel while owning, so this is req[sel] during GRANT
  assign owner_req = |(req & grant);

  // Round-robin pick: first requester above last, otherwise first from index 0.
  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    win_hi   = '0;
    win_lo   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (req[i]) begin
        if (!found_hi && (i > int'(last))) begin
          found_hi = 1'b1;
          win_hi   = SELW'(i);
        end
        if (!found_lo) begin
          found_lo = 1'b1;
          win_lo   = SELW'(i);
        end
      end
    end
    winner = found_hi ? win_hi : win_lo;
  end

  always_comb begin
    state_n     = state;
    grant_n     = grant;
    sel_n       = sel;
    bus_valid_n = bus_valid;
    last_n      = last;
    case (state)
      IDLE, TURN: begin
        if (any_req) begin
          state_n     = GRANT;
          grant_n     = NREQ'(1) << winner;
          sel_n       = winner;
          last_n      = winner;
          bus_valid_n = 1'b1;
        end else begin
          state_n     = IDLE;
          grant_n     = '0;
          bus_valid_n = 1'b0;
        end
      end
      GRANT: begin
        // sel holds through TURN so the mux select does not glitch
        if (!owner_req || revoke) begin
          state_n     = TURN;
          grant_n     = '0;
          bus_valid_n = 1'b0;
        end
      end
      default: begin
        state_n     = IDLE;
        grant_n     = '0;
        bus_valid_n = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state     <= IDLE;
      grant     <= '0;
      sel       <= '0;
      bus_valid <= 1'b0;
      last      <= SELW'(NREQ - 1);
    end else begin
      state     <= state_n;
      grant     <= grant_n;
      sel       <= sel_n;
      bus_valid <= bus_valid_n;
      last      <= last_n;
    end
  end

`ifdef BUS_ARB_TIMEOUT_EN
  localparam int HW = $clog2(MAX_HOLD);
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

  logic [HW-1:0] hold_cnt, hold_cnt_n;
  logic          timeout_r, timeout_n;

  // Only revoke when someone else is waiting; a lone owner keeps the bus.
  assign revoke = (hold_cnt == HOLD_LAST) && ((req & ~grant) != '0);

  always_comb begin
    hold_cnt_n = hold_cnt;
    timeout_n  = 1'b0;
    case (state)
      GRANT: begin
        if (owner_req && revoke) begin
          timeout_n = 1'b1;
        end else if (owner_req && (hold_cnt != HOLD_LAST)) begin
          hold_cnt_n = hold_cnt + 1'b1;
        end
      end
      default: hold_cnt_n = '0;
    endcase
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      hold_cnt  <= '0;
      timeout_r <= 1'b0;
    end else begin
      hold_cnt  <= hold_cnt_n;
      timeout_r <= timeout_n;
    end
  end

  assign timeout = timeout_r;
`else
  assign revoke  = 1'b0;
  assign timeout = 1'b0;
`endif

endmodule
